// File: rtl/mfcc_melbank_pkg.sv
// Shared defaults and FSM encoding for the mel filterbank coefficient loader.
// The loader streams coefficients into a table RAM, then reads them back to verify a checksum.
package mfcc_melbank_pkg;

    localparam int DEF_ADDR_WIDTH = 9;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_SUM_WIDTH  = 16;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LOAD   = 3'd1;
    localparam state_t ST_GAP    = 3'd2;
    localparam state_t ST_VERIFY = 3'd3;
    localparam state_t ST_DONE   = 3'd4;

endpackage

// File: rtl/mfcc_melbank_sum.sv
// Clearable modulo accumulator of zero-extended data words.
// The loader instantiates it twice: once for the write checksum and once for the readback checksum.
module mfcc_melbank_sum
    import mfcc_melbank_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int SUM_WIDTH  = DEF_SUM_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [SUM_WIDTH-1:0]  acc
);

    logic [SUM_WIDTH-1:0] acc_r;

    // Accumulator register; clear has priority over enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= {SUM_WIDTH{1'b0}};
        end else if (clr) begin
            acc_r <= {SUM_WIDTH{1'b0}};
        end else if (en) begin
            acc_r <= acc_r + SUM_WIDTH'(din);
        end else begin
            acc_r <= acc_r;
        end
    end

    assign acc = acc_r;

endmodule

// File: rtl/mfcc_melbank_loader.sv
// Loads a full coefficient table from a valid/ready stream into RAM, then reads it back
// and compares the readback checksum against the write checksum.
module mfcc_melbank_loader
    import mfcc_melbank_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int SUM_WIDTH  = DEF_SUM_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [SUM_WIDTH-1:0]  sum
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO    = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE     = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX     = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH:0]   VCNT_ZERO    = {(ADDR_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH:0]   VCNT_ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   VCNT_RD_END  = {1'b0, {ADDR_WIDTH{1'b1}}};
    localparam logic [ADDR_WIDTH:0]   VCNT_ACC_END = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   VCNT_CMP     = VCNT_ACC_END + VCNT_ONE;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [ADDR_WIDTH-1:0]   counter_r;
    logic [ADDR_WIDTH:0]     vcnt_r;
    logic                    s_ready_r;
    logic                    wr_en_r;
    logic [ADDR_WIDTH-1:0]   wr_addr_r;
    logic [DATA_WIDTH-1:0]   wr_data_r;
    logic [ADDR_WIDTH-1:0]   rd_addr_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    err_r;
    logic [SUM_WIDTH-1:0]    wr_sum_s;
    logic [SUM_WIDTH-1:0]    rb_sum_s;

    logic start_ok_s;
    logic abort_s;
    logic accept_s;
    logic last_beat_s;
    logic rb_en_s;
    logic cmp_s;
    logic mismatch_s;
    logic stay_verify_s;

    assign start_ok_s    = (state_r == ST_IDLE) && start;
    assign abort_s       = abort && ((state_r == ST_LOAD) || (state_r == ST_GAP) || (state_r == ST_VERIFY));
    assign accept_s      = (state_r == ST_LOAD) && s_valid && s_ready_r && !abort;
    assign last_beat_s   = accept_s && (counter_r == ADDR_MAX);
    // rd_data lags rd_addr by one cycle, so accumulation runs on verify cycles 1..DEPTH.
    assign rb_en_s       = (state_r == ST_VERIFY) && (vcnt_r != VCNT_ZERO) && (vcnt_r <= VCNT_ACC_END);
    assign cmp_s         = (state_r == ST_VERIFY) && (vcnt_r == VCNT_CMP);
    assign mismatch_s    = cmp_s && (rb_sum_s != wr_sum_s);
    assign stay_verify_s = (state_r == ST_VERIFY) && (state_nxt_s == ST_VERIFY);

    // Next-state decode; abort overrides every other transition in the active states.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nxt_s = ST_LOAD;
                else       state_nxt_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (abort)            state_nxt_s = ST_IDLE;
                else if (last_beat_s) state_nxt_s = ST_GAP;
                else                  state_nxt_s = ST_LOAD;
            end
            ST_GAP: begin
                if (abort) state_nxt_s = ST_IDLE;
                else       state_nxt_s = ST_VERIFY;
            end
            ST_VERIFY: begin
                if (abort)      state_nxt_s = ST_IDLE;
                else if (cmp_s) state_nxt_s = ST_DONE;
                else            state_nxt_s = ST_VERIFY;
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register and state-derived status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            s_ready_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            s_ready_r <= (state_nxt_s == ST_LOAD);
            busy_r    <= (state_nxt_s == ST_LOAD) || (state_nxt_s == ST_GAP) || (state_nxt_s == ST_VERIFY);
            done_r    <= (state_nxt_s == ST_DONE);
        end
    end

    // Write port and load address counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= ADDR_ZERO;
            wr_data_r <= {DATA_WIDTH{1'b0}};
            counter_r <= ADDR_ZERO;
        end else begin
            wr_en_r <= accept_s;
            if (accept_s) begin
                wr_addr_r <= counter_r;
                wr_data_r <= s_data;
            end
            if (start_ok_s) begin
                counter_r <= ADDR_ZERO;
            end else if (accept_s) begin
                counter_r <= counter_r + ADDR_ONE;
            end
        end
    end

    // Verify sequencing: cycle counter and read address, both parked at zero outside VERIFY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vcnt_r    <= VCNT_ZERO;
            rd_addr_r <= ADDR_ZERO;
        end else begin
            if (stay_verify_s) begin
                vcnt_r <= vcnt_r + VCNT_ONE;
            end else begin
                vcnt_r <= VCNT_ZERO;
            end
            if (stay_verify_s && (vcnt_r < VCNT_RD_END)) begin
                rd_addr_r <= vcnt_r[ADDR_WIDTH-1:0] + ADDR_ONE;
            end else begin
                rd_addr_r <= ADDR_ZERO;
            end
        end
    end

    // Sticky error flag, cleared only by an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (start_ok_s) begin
            err_r <= 1'b0;
        end else if (abort_s || mismatch_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    mfcc_melbank_sum #(
        .DATA_WIDTH (DATA_WIDTH),
        .SUM_WIDTH  (SUM_WIDTH)
    ) u_wr_sum (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_ok_s),
        .en    (accept_s),
        .din   (s_data),
        .acc   (wr_sum_s)
    );

    mfcc_melbank_sum #(
        .DATA_WIDTH (DATA_WIDTH),
        .SUM_WIDTH  (SUM_WIDTH)
    ) u_rb_sum (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_ok_s),
        .en    (rb_en_s),
        .din   (rd_data),
        .acc   (rb_sum_s)
    );

    assign s_ready = s_ready_r;
    assign wr_en   = wr_en_r;
    assign wr_addr = wr_addr_r;
    assign wr_data = wr_data_r;
    assign rd_addr = rd_addr_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign err     = err_r;
    assign sum     = wr_sum_s;

endmodule

// File: tb/tb_mfcc_melbank_loader.sv
// Scoreboard bench for mfcc_melbank_loader: stimulus queues expected writes and completions,
// a negedge monitor pops and compares them whenever the DUT writes or signals done.
module tb_mfcc_melbank_loader;

    logic        clk_tb;
    logic        tb_rst;
    logic        start;
    logic        abort;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        wr_en;
    logic [8:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [8:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] sum;

    typedef struct { logic [8:0] addr; logic [7:0] data; } wr_t;
    typedef struct { int cyc; logic err; logic [15:0] sum; } done_t;

    wr_t   exp_wr[$];
    done_t exp_done[$];
    wr_t   mon_w;
    done_t mon_d;
    int    n_vec = 0;
    int    n_fail = 0;
    int    cyc = 0;

    logic [7:0] mem [512];
    logic [7:0] rd_q;
    logic       ram_fault;

    mfcc_melbank_loader dut (
        .clk     (clk_tb),
        .rst_n   (tb_rst),
        .start   (start),
        .abort   (abort),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .sum     (sum)
    );

    initial clk_tb = 1'b0;
    always #5 clk_tb = ~clk_tb;

    always @(posedge clk_tb) cyc <= cyc + 1;

    // Synchronous-read RAM; the fault option corrupts the word read back from address 100.
    always @(posedge clk_tb) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_q <= (ram_fault && rd_addr == 9'd100) ? 8'hFF : mem[rd_addr];
    end
    assign rd_data = rd_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        check({tag, "_wr_en"},   32'(wr_en),   32'd0);
        check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        check({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
        check({tag, "_busy"},    32'(busy),    32'd0);
        check({tag, "_done"},    32'(done),    32'd0);
        check({tag, "_err"},     32'(err),     32'd0);
        check({tag, "_sum"},     32'(sum),     32'd0);
    endtask

    // Monitor: every write and every done pulse must match the head of its queue.
    always @(negedge clk_tb) begin
        if (tb_rst) begin
            if (wr_en) begin
                if (exp_wr.size() == 0) begin
                    check("wr_unexpected", 32'(wr_en), 32'd0);
                end else begin
                    mon_w = exp_wr.pop_front();
                    check("wr_addr", 32'(wr_addr), 32'(mon_w.addr));
                    check("wr_data", 32'(wr_data), 32'(mon_w.data));
                end
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    check("done_unexpected", 32'(done), 32'd0);
                end else begin
                    mon_d = exp_done.pop_front();
                    check("done_cycle", 32'(cyc), 32'(mon_d.cyc));
                    check("done_err",   32'(err), 32'(mon_d.err));
                    check("done_sum",   32'(sum), 32'(mon_d.sum));
                end
            end
        end
    end

    // mode 0: ramp data back-to-back, 1: ramp on alternate cycles, 2: random data and gaps.
    // stop_at >= 0 aborts (or resets when stop_rst) instead of delivering that beat.
    task automatic run_load(input int mode, input logic fault, input int stop_at,
                            input logic stop_rst, input int dup_at);
        logic [7:0]  d;
        logic [31:0] wsum = 32'd0;
        logic [31:0] rsum = 32'd0;
        int          last_edge = 0;
        int          k = 0;
        ram_fault = fault;
        @(negedge clk_tb);
        start = 1'b1;
        @(negedge clk_tb);
        start = 1'b0;
        check("start_busy",    32'(busy), 32'd1);
        check("start_err_clr", 32'(err),  32'd0);
        check("start_sum_clr", 32'(sum),  32'd0);
        for (int i = 0; i < 512; i++) begin
            int gap;
            if (mode == 1)      gap = (i > 0) ? 1 : 0;
            else if (mode == 2) gap = int'($urandom_range(0, 2));
            else                gap = 0;
            s_valid = 1'b0;
            repeat (gap) @(negedge clk_tb);
            d = (mode == 2) ? 8'($urandom_range(0, 255)) : 8'(i);
            s_valid = 1'b1;
            s_data  = d;
            if (i == stop_at) begin
                if (stop_rst) begin
                    @(posedge clk_tb);
                    #2 tb_rst = 1'b0;
                    #1 check_reset_outputs("rst_mid_load");
                    exp_wr.delete();
                    s_valid = 1'b0;
                    repeat (3) @(negedge clk_tb);
                    tb_rst = 1'b1;
                    repeat (10) @(negedge clk_tb);
                    check("no_autostart_busy",  32'(busy),    32'd0);
                    check("no_autostart_ready", 32'(s_ready), 32'd0);
                end else begin
                    abort = 1'b1;
                    @(negedge clk_tb);
                    abort   = 1'b0;
                    s_valid = 1'b0;
                    check("abort_busy",    32'(busy),    32'd0);
                    check("abort_err",     32'(err),     32'd1);
                    check("abort_s_ready", 32'(s_ready), 32'd0);
                    check("abort_wr_en",   32'(wr_en),   32'd0);
                    check("abort_rd_addr", 32'(rd_addr), 32'd0);
                    repeat (30) @(negedge clk_tb);
                    check("abort_pending_writes", 32'(exp_wr.size()), 32'd0);
                    check("abort_stays_idle",     32'(busy),          32'd0);
                end
                return;
            end
            if (i == dup_at) start = 1'b1;
            exp_wr.push_back('{addr: 9'(i), data: d});
            wsum = wsum + 32'(d);
            rsum = rsum + ((fault && i == 100) ? 32'hFF : 32'(d));
            last_edge = cyc + 1;
            @(negedge clk_tb);
            start = 1'b0;
        end
        s_valid = 1'b0;
        exp_done.push_back('{cyc: last_edge + 515, err: (wsum[15:0] != rsum[15:0]), sum: wsum[15:0]});
        while (exp_done.size() != 0 && k < 2000) begin
            @(negedge clk_tb);
            k++;
        end
        check("done_seen", 32'(exp_done.size()), 32'd0);
        exp_done.delete();
        @(negedge clk_tb);
        check("after_done_busy",    32'(busy),    32'd0);
        check("after_done_rd_addr", 32'(rd_addr), 32'd0);
    endtask

    initial begin
        tb_rst    = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        s_valid   = 1'b0;
        s_data    = 8'd0;
        ram_fault = 1'b0;
        #1 check_reset_outputs("por");
        repeat (3) @(negedge clk_tb);
        tb_rst = 1'b1;
        repeat (5) @(negedge clk_tb);
        check("idle_busy",    32'(busy),    32'd0);
        check("idle_rd_addr", 32'(rd_addr), 32'd0);

        run_load(0, 1'b0, -1, 1'b0, -1);
        run_load(1, 1'b0, -1, 1'b0, -1);
        run_load(0, 1'b1, -1, 1'b0, -1);
        check("err_sticky", 32'(err), 32'd1);
        check("sum_holds",  32'(sum), 32'hFF00);
        run_load(2, 1'b0, -1, 1'b0, -1);
        run_load(0, 1'b0, 200, 1'b0, -1);
        run_load(0, 1'b0, -1, 1'b0, -1);
        check("clean_after_abort_err", 32'(err), 32'd0);

        abort = 1'b1;
        @(negedge clk_tb);
        abort = 1'b0;
        check("idle_abort_err",  32'(err),  32'd0);
        check("idle_abort_busy", 32'(busy), 32'd0);

        run_load(2, 1'b0, 300, 1'b1, -1);
        run_load(2, 1'b0, -1, 1'b0, 150);

        repeat (5) @(negedge clk_tb);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mfcc_melbank_loader.md
MFCC_MELBANK_LOADER -- requirements
Module: mfcc_melbank_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9, table address width (depth 2**ADDR_WIDTH = 512).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, coefficient width.
REQ-003 SHALL have parameter SUM_WIDTH, default 16, checksum width.
REQ-004 SHALL have ports as listed below.
- clk  input  1  single clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a load.
- abort  input  1  cancels an active load or verify.
- s_data  input  DATA_WIDTH  coefficient stream data.
- s_valid  input  1  s_data valid.
- s_ready  output  1  loader accepts s_data.
- wr_en  output  1  RAM write strobe.
- wr_addr  output  ADDR_WIDTH  RAM write address.
- wr_data  output  DATA_WIDTH  RAM write data.
- rd_addr  output  ADDR_WIDTH  RAM read address (RAM returns data 1 cycle later, unregistered output).
- rd_data  input  DATA_WIDTH  RAM read data.
- busy  output  1  high in LOAD, GAP and VERIFY.
- done  output  1  one-cycle pulse when verify completes.
- err  output  1  sticky error flag, cleared by accepted start.
- sum  output  SUM_WIDTH  write checksum of the last load.

Function
REQ-005 SHALL implement states IDLE, LOAD, GAP, VERIFY, DONE.
REQ-006 IDLE: s_ready=0, wr_en=0; start=1 -> LOAD, clear counter, sum, readback sum and err.
REQ-007 LOAD: s_ready=1; each cycle with s_valid&s_ready SHALL register wr_en=1, wr_addr=counter, wr_data=s_data on the next edge, then increment counter.
REQ-008 Cycles with s_valid=0 SHALL produce wr_en=0; counter and sum hold.
REQ-009 sum SHALL accumulate zero-extended s_data modulo 2**SUM_WIDTH per accepted beat.
REQ-010 Acceptance at counter=2**ADDR_WIDTH-1 SHALL move to GAP; s_ready drops the following cycle; counter wraps to 0.
REQ-011 GAP: one cycle, lets the final write land; -> VERIFY.
REQ-012 VERIFY: rd_addr SHALL step 0..2**ADDR_WIDTH-1, one per cycle; rd_data for each address SHALL be accumulated exactly one cycle later into the readback sum.
REQ-013 After the last readback accumulates, the readback sum SHALL be compared with sum; mismatch sets err=1; -> DONE.
REQ-014 DONE: done=1 for exactly one cycle; -> IDLE. busy=0 in DONE.
REQ-015 With continuous s_valid, done SHALL assert 1027 cycles after the edge sampling start (512 LOAD + 1 GAP + 512 VERIFY + 1 latency + 1 DONE).
REQ-016 start outside IDLE SHALL be ignored.
REQ-017 abort in LOAD/GAP/VERIFY SHALL go to IDLE next edge, set err=1, suppress done, drop wr_en; abort in IDLE/DONE ignored.
REQ-018 abort and s_valid in the same LOAD cycle: abort wins, beat not written.
REQ-019 rd_addr SHALL be 0 outside VERIFY.

Reset
REQ-020 rst_n low SHALL immediately force IDLE and s_ready=0, wr_en=0, wr_addr=0, wr_data=0, rd_addr=0, busy=0, done=0, err=0, sum=0, counters 0, including mid-LOAD or mid-VERIFY.
REQ-021 Deassertion SHALL not start a load; start is required.

Structure
REQ-022 Package mfcc_melbank_pkg SHALL hold ADDR_WIDTH/DATA_WIDTH/SUM_WIDTH defaults and the state encoding.
REQ-023 One sub-module mfcc_melbank_sum (clear/enable modulo accumulator) SHALL be instantiated twice: write sum and readback sum.

Verification
REQ-024 start, continuous s_valid, s_data=i[7:0] for i=0..511, ideal RAM -> 512 writes wr_addr=i, sum=0xFF00, err=0, done at cycle 1027.
REQ-025 Same data, s_valid on alternate cycles -> identical write sequence, sum=0xFF00, err=0, done 511 cycles later than REQ-024.
REQ-026 RAM model returns 0xFF at addr 100 instead of 0x64 -> done pulses, err=1, sum=0xFF00.
REQ-027 abort after 200th beat -> IDLE next cycle, busy=0, err=1, no done; following clean load per REQ-024 -> err=0.
REQ-028 rst_n low at beat 300, then start pulse during a second load -> all outputs at reset values immediately; ignored start leaves sequence unchanged.
